// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the seven-segment scan controller.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    typedef enum logic [1:0] {
        DIG_ONES,
        DIG_TENS,
        DIG_HUNDREDS
    } digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] add3_nibbles(input logic [11:0] acc);
        logic [11:0] result;
        result = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                result[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment decoder; non-decimal codes blank the digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Binary-to-BCD converter with a three-digit multiplexed seven-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on hundreds/tens.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

    conv_state_t        state;
    logic [7:0]         shift_reg;
    logic [11:0]        acc;
    logic [11:0]        acc_adj;
    logic [2:0]         step;

    logic [PRESC_W-1:0] presc;
    digit_t             digit;
    logic [3:0]         nibble;
    logic               blank;
    logic [3:0]         dec_in;

    assign acc_adj = add3_nibbles(acc);

    // bcd_out is only written on the DONE exit, so the display never sees a partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= 12'h000;
            shift_reg <= 8'h00;
            acc       <= 12'h000;
            step      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        shift_reg <= value_in;
                        acc       <= 12'h000;
                        step      <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, shift_reg} <= {acc_adj[10:0], shift_reg, 1'b0};
                    step             <= step + 3'd1;
                    if (step == 3'd7) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out <= acc;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= DIG_ONES;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            case (digit)
                DIG_ONES:     digit <= DIG_TENS;
                DIG_TENS:     digit <= DIG_HUNDREDS;
                default:      digit <= DIG_ONES;
            endcase
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_comb begin
        an_n   = 4'b1111;
        nibble = bcd_out[3:0];
        blank  = 1'b0;
        case (digit)
            DIG_ONES: begin
                an_n   = 4'b1110;
                nibble = bcd_out[3:0];
            end
            DIG_TENS: begin
                an_n   = 4'b1101;
                nibble = bcd_out[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
`endif
            end
            DIG_HUNDREDS: begin
                an_n   = 4'b1011;
                nibble = bcd_out[11:8];
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd_out[11:8] == 4'd0);
`endif
            end
            default: begin
                an_n   = 4'b1111;
                nibble = bcd_out[3:0];
            end
        endcase
        // A non-decimal code makes the decoder output the blank pattern.
        dec_in = blank ? 4'hF : nibble;
    end

    seg7_decode u_decode (
        .bcd (dec_in),
        .seg (seg_n)
    );

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Sequential controller for the three-digit seven-segment readout of the chasing-LED board.
- Accepts an 8-bit binary value on a load strobe and converts it to three BCD digits with an 8-step shift-add-3 (double-dabble) sequence.
- Holds the result in display registers.
- Time-multiplexes hundreds/tens/ones onto one shared active-low segment bus with active-low digit enables.

## Interface
- SCAN_DIV, 100000, clock cycles each digit stays enabled (1 kHz per digit at 100 MHz); legal range ≥ 2
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- value_in  in  8  binary value to display, sampled on accepted load
- load  in  1  load request; accepted only when busy=0
- busy  out  1  conversion in progress; loads ignored while high
- done  out  1  one-cycle pulse: conversion finished, display registers update at end of this cycle
- bcd_out  out  12  display registers {hundreds,tens,ones}, 4 bits each
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
- an_n  out  4  active-low digit enables; [0]=ones, [1]=tens, [2]=hundreds, [3] always 1

## Operation
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE + load=1: capture value_in into shift register, clear BCD accumulator and step counter, go to SHIFT.
  - SHIFT, 8 cycles (step 0..7):
    - add 3 to every accumulator nibble ≥ 5;
    - then shift {accumulator, shift register} left by one;
    - after step 7, go to DONE.
  - DONE, 1 cycle: done=1; bcd_out <= accumulator at the closing edge; return to IDLE.
- busy = (state != IDLE). load is ignored in SHIFT and DONE; there is no queueing.
- Scan path:
  - prescaler counts 0..SCAN_DIV-1; at wrap, digit index advances ones→tens→hundreds→ones.
  - an_n and seg_n are combinational from the registered index and bcd_out, through the decoder.
- Digit codes (seg_n):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111; any nibble > 9 also decodes to blank (cannot occur after a legal conversion).
- Scan runs continuously, independent of conversion.
- bcd_out changes only at the end of DONE, so a digit never shows a partial result.

## Timing
- Reset values: state IDLE, busy=0, done=0, bcd_out=12'h000, index=ones, prescaler=0, an_n=4'b1110, seg_n=7'b1000000.
- Load accepted at edge k:
  - busy=1 from cycle k+1 to k+9 inclusive;
  - done=1 during cycle k+9 only;
  - bcd_out valid from edge k+10.
- Earliest next accepted load is at edge k+10 (throughput 1 per 10 cycles).
- load held high continuously: reloads at every IDLE visit.
- Reset mid-conversion: FSM returns to IDLE, bcd_out cleared, no done pulse.
- Each digit is enabled for exactly SCAN_DIV cycles; the scan period is 3×SCAN_DIV.
- A bcd_out update mid-slot takes effect immediately on the enabled digit; it does not restart the slot.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - hundreds digit blanks when its nibble is 0;
  - tens digit blanks when hundreds and tens are both 0;
  - ones digit is never blanked;
  - an_n still enables the blanked digit slot.
- LEADING_ZERO_BLANK_EN undefined: all three digits always show their decoded value, including leading zeros.
- Blanking affects seg_n only; bcd_out is unaffected.

## Structure
- Package seg7_pkg: FSM state enum {IDLE, SHIFT, DONE}, digit-index enum {DIG_ONES, DIG_TENS, DIG_HUNDREDS}, segment code constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module seg7_decode: 4-bit BCD in → 7-bit active-low segments out, combinational; instantiated once on the muxed digit.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 → an_n=1110, seg_n=1000000, busy=0, done=0, bcd_out=000.
- Load 8'd255 at edge k → busy=1 at k+1; done=1 only in cycle k+9; bcd_out=12'h255 from k+10.
- SCAN_DIV=4, load 8'd137, no blanking → repeating sequence, each step 4 cycles:
  - an_n=1110 with seg_n=1111000;
  - an_n=1101 with 0110000;
  - an_n=1011 with 1111001.
- Load 8'd200, then load=1 with value_in=8'd42 at cycles k+3 and k+9 → both ignored; bcd_out=12'h200; one done pulse.
- Load 8'd99, rst_n=0 at cycle k+5 → next cycle busy=0, bcd_out=000; no done pulse.
- Value 8'd7, with LEADING_ZERO_BLANK_EN → hundreds/tens seg_n=1111111, ones 1111000.
  - Without the macro: hundreds and tens show 1000000.
  - Value 8'd0 with the macro: ones shows 1000000.
